// File: rtl/io_pwm_bank.sv
// io_pwm_bank: CPU-mapped bank of N_CH 8-bit PWM channels with shared prescaler.
// Define IO_PWM_READBACK_EN to build the registered read path (rdata/rhit).
module io_pwm_bank #(
    parameter logic [15:0] BASE_ADDR = 16'h0400,
    parameter int          N_CH      = 3,
    parameter logic [7:0]  PRESC_RST = 8'd0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     addr,
    input  logic [7:0]      wdata,
    input  logic            we,
    output logic [7:0]      rdata,
    output logic            rhit,
    output logic [N_CH-1:0] pwm_out
);

    logic       hit;
    logic [3:0] off;
    logic       wr;
    logic       presc_wr;

    assign hit      = addr[15:4] == BASE_ADDR[15:4];
    assign off      = addr[3:0];
    assign wr       = we && hit;
    assign presc_wr = wr && (off == 4'd1);

    logic       en;
    logic       inv;
    logic [7:0] presc;
    logic [7:0] pc;
    logic [7:0] cnt;
    logic       tick;
    logic       wrap;
    logic [7:0] duty_pend [N_CH];
    logic [7:0] duty_act  [N_CH];

    assign tick = en && (pc == presc);
    assign wrap = tick && (cnt == 8'hFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en    <= 1'b0;
            inv   <= 1'b0;
            presc <= PRESC_RST;
        end else begin
            if (wr && off == 4'd0) begin
                en  <= wdata[0];
                inv <= wdata[1];
            end
            if (presc_wr)
                presc <= wdata;
        end
    end

    // Counters are parked at zero while disabled so enabling starts a clean period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc  <= 8'd0;
            cnt <= 8'd0;
        end else if (!en) begin
            pc  <= 8'd0;
            cnt <= 8'd0;
        end else begin
            if (presc_wr || tick)
                pc <= 8'd0;
            else
                pc <= pc + 8'd1;
            if (tick)
                cnt <= cnt + 8'd1;
        end
    end

    // A duty write landing on the wrap edge goes straight to the active copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                duty_pend[i] <= 8'd0;
                duty_act[i]  <= 8'd0;
            end
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (wr && off == 4'(i + 2))
                    duty_pend[i] <= wdata;
                if (wrap)
                    duty_act[i] <= (wr && off == 4'(i + 2)) ? wdata : duty_pend[i];
                pwm_out[i] <= en ? ((cnt < duty_act[i]) ^ inv) : inv;
            end
        end
    end

`ifdef IO_PWM_READBACK_EN
    logic [7:0] rd_mux;

    always_comb begin
        rd_mux = 8'h00;
        if (off == 4'd0)
            rd_mux = {6'd0, inv, en};
        else if (off == 4'd1)
            rd_mux = presc;
        for (int i = 0; i < N_CH; i++)
            if (off == 4'(i + 2))
                rd_mux = duty_pend[i];
        if (!hit)
            rd_mux = 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= 8'h00;
            rhit  <= 1'b0;
        end else begin
            rdata <= rd_mux;
            rhit  <= hit;
        end
    end
`else
    assign rdata = 8'h00;
    assign rhit  = 1'b0;
`endif

endmodule
